spec_sg_monitor: RTL
====================

# spec_sg_monitor

Synthesisable, run-time successor to the formal spec-binding checker. It tracks a state graph (SG) loaded into an internal transition table and watches a vector of circuit signals each clock. It reports spec-compliance, output-persistency, multi-change and deadlock violations as a sticky, first-error-captured status. It sits beside the synchronous circuit model in simulation or FPGA prototyping, in place of bound SVA properties.

## Interface
Parameters:
- NSIG, 4: number of monitored signals (inputs and outputs of the SG).
- NSTATE, 16: number of SG states; STATE_W = $clog2(NSTATE).
- NTRANS, 32: transition-table depth; ADDR_W = $clog2(NTRANS).
- OUT_MASK, '0: NSIG-bit mask; 1 = circuit output/internal (assert class), 0 = environment input (assume class).
- INIT_STATE, 0: SG state loaded on reset.
- INIT_SIG, '0: signal values expected on reset.
- DL_LIMIT, 64: consecutive idle cycles before deadlock is flagged; counter width $clog2(DL_LIMIT+1).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- cfg_we  in  1  table write strobe; ignored while run=1.
- cfg_addr  in  ADDR_W  table entry index.
- cfg_from  in  STATE_W  source state.
- cfg_sig  in  $clog2(NSIG)  signal index.
- cfg_dir  in  1  1 = rise (+), 0 = fall (-).
- cfg_to  in  STATE_W  destination state.
- run  in  1  monitoring enable.
- sig  in  NSIG  current signal values.
- ena  in  NSIG  per-signal excitation (precap != output); only OUT_MASK bits are used.
- err_clr  in  1  clears sticky error fields; state is not touched.
- state  out  STATE_W  current SG state.
- err  out  1  sticky violation flag.
- err_code  out  3  NONE / IN_NONCOMPLY / OUT_NONCOMPLY / PERSIST / MULTI / DEADLOCK.
- err_sig  out  $clog2(NSIG)  offending signal index (0 for DEADLOCK).
- err_state  out  STATE_W  SG state at time of violation.
- trans_cnt  out  32  accepted transitions, wraps modulo 2^32.

## Operation
- Reset values:
  - state=INIT_STATE; sig_q=INIT_SIG; all table valid bits=0.
  - err=0; err_code=NONE; err_sig=0; err_state=0.
  - trans_cnt=0; idle counter=0; ena_q=0.
- Table writes:
  - cfg_we with run=0 writes {valid=1, from, sig, dir, to} at cfg_addr.
  - Rewriting an address overwrites it.
- Monitoring only when run=1. With run=0, sig_q tracks sig each cycle and no checks fire.
- Each cycle: chg = sig ^ sig_q.
- chg one-hot on bit i:
  - Lookup searches for a valid entry with from==state, sig==i, dir==sig[i].
  - Lowest matching address wins.
  - Hit: state<=to and trans_cnt++.
  - Miss: IN_NONCOMPLY if OUT_MASK[i]=0, else OUT_NONCOMPLY. State holds.
- popcount(chg)>1: MULTI, with err_sig = lowest changed index. State holds.
- Persistency: for OUT_MASK bit i, ena_q[i] && !ena[i] && !chg[i] -> PERSIST.
- Deadlock:
  - Idle cycle = chg==0 && (ena & OUT_MASK)==0.
  - The idle counter increments on each idle cycle, clears on any non-idle cycle, and saturates.
  - Reaching DL_LIMIT raises DEADLOCK once.
- Error capture:
  - Only the first violation loads err_code/err_sig/err_state; later violations are ignored until err_clr.
  - Same-cycle priority: MULTI > OUT_NONCOMPLY > IN_NONCOMPLY > PERSIST > DEADLOCK.
  - For PERSIST, the lowest violating index is reported.
- Monitoring continues after an error: state still advances on hits.
- err_clr has priority over a same-cycle new violation, which is dropped.

## Timing
- All outputs are registered.
- state, trans_cnt and error fields update on the clk edge after sig changes, i.e. one cycle after the change is visible on sig.
- A table write is visible to lookup on the next cycle.
- reset asserted mid-operation restores all reset values at the next edge, including invalidating the table; software must reload the table before run.
- run rising: the first checked cycle compares against the sig_q captured while run=0, so no spurious change is seen.

## Structure
- Package spec_mon_pkg:
  - err_code_e enum.
  - sg_entry_t struct {valid, from, sig, dir, to}.
  - Error-priority constants.
- Sub-module spec_sg_table:
  - Register-array table with write port.
  - Combinational parallel match with a priority encoder.
  - Outputs hit and to.
- Top level holds sig_q/ena_q, the checkers, the idle counter and error capture.

## Test plan
- Handshake SG (req/ack; req input, ack output), 4 states; sequence req+, ack+, req-, ack- -> state 0→1→2→3→0, trans_cnt=4, err=0.
- ack+ driven in state 0 -> next cycle err=1, err_code=OUT_NONCOMPLY, err_sig=1, err_state=0; state stays 0.
- req and ack toggle in the same cycle -> err_code=MULTI, err_sig=0; a later PERSIST does not overwrite the capture; after err_clr, err=0.
- ena[ack]=1 for one cycle, then 0 with ack unchanged -> err_code=PERSIST, err_sig=1.
- DL_LIMIT=8, no activity -> err asserted exactly on the 8th idle cycle; a single toggle at cycle 7 restarts the count.
- Reset asserted mid-sequence in state 2 -> next cycle state=INIT_STATE, trans_cnt=0; a previously valid transition now gives a NONCOMPLY error because the table was invalidated.

Source files
------------

// File: rtl/spec_sg_monitor_pkg.sv
// Shared types for the state-graph monitor: error codes, transition-table
// entry layout and same-cycle error priority.
package spec_mon_pkg;

  typedef enum logic [2:0] {
    ERR_NONE          = 3'd0,
    ERR_IN_NONCOMPLY  = 3'd1,
    ERR_OUT_NONCOMPLY = 3'd2,
    ERR_PERSIST       = 3'd3,
    ERR_MULTI         = 3'd4,
    ERR_DEADLOCK      = 3'd5
  } err_code_e;

  // Entries are stored at a fixed maximum width so one type serves every
  // NSTATE/NSIG configuration up to 256 states and 256 signals.
  localparam int SG_STATE_MAX_W = 8;
  localparam int SG_SIG_MAX_W   = 8;

  typedef struct packed {
    logic                      valid;
    logic [SG_STATE_MAX_W-1:0] from;
    logic [SG_SIG_MAX_W-1:0]   sig;
    logic                      dir;
    logic [SG_STATE_MAX_W-1:0] to;
  } sg_entry_t;

  localparam int PRIO_DEADLOCK = 0;
  localparam int PRIO_PERSIST  = 1;
  localparam int PRIO_IN       = 2;
  localparam int PRIO_OUT      = 3;
  localparam int PRIO_MULTI    = 4;
  localparam int NPRIO         = 5;

  function automatic err_code_e err_pick(input logic [NPRIO-1:0] v);
    err_code_e c;
    c = ERR_NONE;
    if (v[PRIO_MULTI])         c = ERR_MULTI;
    else if (v[PRIO_OUT])      c = ERR_OUT_NONCOMPLY;
    else if (v[PRIO_IN])       c = ERR_IN_NONCOMPLY;
    else if (v[PRIO_PERSIST])  c = ERR_PERSIST;
    else if (v[PRIO_DEADLOCK]) c = ERR_DEADLOCK;
    return c;
  endfunction

endpackage

// File: rtl/spec_sg_monitor_if.sv
// Config/observation bundle between the monitor and whatever drives it.
interface spec_sg_monitor_if #(
  parameter int NSIG   = 4,
  parameter int NSTATE = 16,
  parameter int NTRANS = 32
);
  localparam int STATE_W = $clog2(NSTATE);
  localparam int ADDR_W  = $clog2(NTRANS);
  localparam int SIG_W   = $clog2(NSIG);

  logic               cfg_we;
  logic [ADDR_W-1:0]  cfg_addr;
  logic [STATE_W-1:0] cfg_from;
  logic [SIG_W-1:0]   cfg_sig;
  logic               cfg_dir;
  logic [STATE_W-1:0] cfg_to;
  logic               run;
  logic [NSIG-1:0]    sig;
  logic [NSIG-1:0]    ena;
  logic               err_clr;
  logic [STATE_W-1:0] state;
  logic               err;
  logic [2:0]         err_code;
  logic [SIG_W-1:0]   err_sig;
  logic [STATE_W-1:0] err_state;
  logic [31:0]        trans_cnt;

  modport master (
    output cfg_we, cfg_addr, cfg_from, cfg_sig, cfg_dir, cfg_to,
    output run, sig, ena, err_clr,
    input  state, err, err_code, err_sig, err_state, trans_cnt
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_from, cfg_sig, cfg_dir, cfg_to,
    input  run, sig, ena, err_clr,
    output state, err, err_code, err_sig, err_state, trans_cnt
  );
endinterface

// File: rtl/spec_sg_monitor_table.sv
// SG transition table: register array with one write port and a fully
// parallel lookup; the lowest matching address wins.
module spec_sg_table
  import spec_mon_pkg::*;
#(
  parameter int NSIG   = 4,
  parameter int NSTATE = 16,
  parameter int NTRANS = 32,
  localparam int STATE_W = $clog2(NSTATE),
  localparam int ADDR_W  = $clog2(NTRANS),
  localparam int SIG_W   = $clog2(NSIG)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [STATE_W-1:0] wfrom,
  input  logic [SIG_W-1:0]   wsig,
  input  logic               wdir,
  input  logic [STATE_W-1:0] wto,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [SIG_W-1:0]   lk_sig,
  input  logic               lk_dir,
  output logic               hit,
  output logic [STATE_W-1:0] to
);

  sg_entry_t                 tbl [NTRANS];
  sg_entry_t                 wentry;
  sg_entry_t                 sel;
  logic [NTRANS-1:0]         match;
  logic [SG_STATE_MAX_W-1:0] cur_ext;
  logic [SG_SIG_MAX_W-1:0]   sig_ext;
  logic                      unused_sel;

  always_comb begin
    wentry       = '0;
    wentry.valid = 1'b1;
    wentry.from  = SG_STATE_MAX_W'(wfrom);
    wentry.sig   = SG_SIG_MAX_W'(wsig);
    wentry.dir   = wdir;
    wentry.to    = SG_STATE_MAX_W'(wto);
  end

  // Only the valid bits need a reset; payload is don't-care until written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < NTRANS; a++) tbl[a].valid <= 1'b0;
    end else if (we) begin
      tbl[waddr] <= wentry;
    end
  end

  assign cur_ext = SG_STATE_MAX_W'(cur_state);
  assign sig_ext = SG_SIG_MAX_W'(lk_sig);

  for (genvar a = 0; a < NTRANS; a++) begin : g_match
    assign match[a] = tbl[a].valid && (tbl[a].from == cur_ext) &&
                      (tbl[a].sig == sig_ext) && (tbl[a].dir == lk_dir);
  end

  always_comb begin
    sel = '0;
    for (int a = NTRANS - 1; a >= 0; a--) begin
      if (match[a]) sel = tbl[a];
    end
  end

  assign hit        = sel.valid;
  assign to         = sel.to[STATE_W-1:0];
  assign unused_sel = ^{sel.from, sel.sig, sel.dir, sel.to[SG_STATE_MAX_W-1:STATE_W]};

endmodule

// File: rtl/spec_sg_monitor.sv
// Run-time state-graph monitor: tracks the SG state from observed signal
// edges and captures the first compliance/persistency/multi/deadlock error.
module spec_sg_monitor
  import spec_mon_pkg::*;
#(
  parameter int              NSIG       = 4,
  parameter int              NSTATE     = 16,
  parameter int              NTRANS     = 32,
  parameter logic [NSIG-1:0] OUT_MASK   = '0,
  parameter int              INIT_STATE = 0,
  parameter logic [NSIG-1:0] INIT_SIG   = '0,
  parameter int              DL_LIMIT   = 64
) (
  input logic              clk,
  input logic              reset,
  spec_sg_monitor_if.slave bus
);

  localparam int STATE_W = $clog2(NSTATE);
  localparam int SIG_W   = $clog2(NSIG);
  localparam int DL_W    = $clog2(DL_LIMIT + 1);

  logic [NSIG-1:0]    sig_q, ena_q, chg, pers;
  logic [STATE_W-1:0] state_q;
  logic [31:0]        trans_cnt_q;
  logic [DL_W-1:0]    idle_cnt;
  logic               err_q;
  err_code_e          code_q;
  logic [SIG_W-1:0]   esig_q;
  logic [STATE_W-1:0] estate_q;

  logic               one_hot, multi, idle, dl_fire, lk_hit, take;
  logic [STATE_W-1:0] lk_to;
  logic [SIG_W-1:0]   chg_lo, pers_lo, new_sig;
  logic [NPRIO-1:0]   viol;
  err_code_e          new_code;

  // sig_q follows sig even while run=0, so enabling run never sees a stale edge.
  assign chg     = bus.sig ^ sig_q;
  assign one_hot = bus.run && $onehot(chg);
  assign multi   = bus.run && !$onehot0(chg);
  assign pers    = bus.run ? (OUT_MASK & ena_q & ~bus.ena & ~chg) : '0;
  assign idle    = (chg == '0) && ((bus.ena & OUT_MASK) == '0);
  assign dl_fire = bus.run && idle && (idle_cnt == DL_W'(DL_LIMIT - 1));

  always_comb begin
    chg_lo  = '0;
    pers_lo = '0;
    for (int i = NSIG - 1; i >= 0; i--) begin
      if (chg[i])  chg_lo  = SIG_W'(i);
      if (pers[i]) pers_lo = SIG_W'(i);
    end
  end

  spec_sg_table #(
    .NSIG   (NSIG),
    .NSTATE (NSTATE),
    .NTRANS (NTRANS)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .we        (bus.cfg_we && !bus.run),
    .waddr     (bus.cfg_addr),
    .wfrom     (bus.cfg_from),
    .wsig      (bus.cfg_sig),
    .wdir      (bus.cfg_dir),
    .wto       (bus.cfg_to),
    .cur_state (state_q),
    .lk_sig    (chg_lo),
    .lk_dir    (bus.sig[chg_lo]),
    .hit       (lk_hit),
    .to        (lk_to)
  );

  assign take = one_hot && lk_hit;

  always_comb begin
    viol                = '0;
    viol[PRIO_MULTI]    = multi;
    viol[PRIO_OUT]      = one_hot && !lk_hit && OUT_MASK[chg_lo];
    viol[PRIO_IN]       = one_hot && !lk_hit && !OUT_MASK[chg_lo];
    viol[PRIO_PERSIST]  = |pers;
    viol[PRIO_DEADLOCK] = dl_fire;
  end

  assign new_code = err_pick(viol);

  always_comb begin
    new_sig = '0;
    case (new_code)
      ERR_MULTI, ERR_OUT_NONCOMPLY, ERR_IN_NONCOMPLY: new_sig = chg_lo;
      ERR_PERSIST:                                    new_sig = pers_lo;
      default:                                        new_sig = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q       <= INIT_SIG;
      ena_q       <= '0;
      state_q     <= STATE_W'(INIT_STATE);
      trans_cnt_q <= '0;
      idle_cnt    <= '0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
      esig_q      <= '0;
      estate_q    <= '0;
    end else begin
      sig_q <= bus.sig;
      ena_q <= bus.ena;
      if (take) begin
        state_q     <= lk_to;
        trans_cnt_q <= trans_cnt_q + 32'd1;
      end
      // Saturating at DL_LIMIT keeps a long stall from re-raising deadlock.
      if (!bus.run || !idle)
        idle_cnt <= '0;
      else if (idle_cnt != DL_W'(DL_LIMIT))
        idle_cnt <= idle_cnt + DL_W'(1);
      if (bus.err_clr) begin
        err_q    <= 1'b0;
        code_q   <= ERR_NONE;
        esig_q   <= '0;
        estate_q <= '0;
      end else if (!err_q && (new_code != ERR_NONE)) begin
        err_q    <= 1'b1;
        code_q   <= new_code;
        esig_q   <= new_sig;
        estate_q <= state_q;
      end
    end
  end

  assign bus.state     = state_q;
  assign bus.err       = err_q;
  assign bus.err_code  = code_q;
  assign bus.err_sig   = esig_q;
  assign bus.err_state = estate_q;
  assign bus.trans_cnt = trans_cnt_q;

endmodule
